// File: rtl/mmio_store_mailbox.sv
// mmio_store_mailbox: memory-mapped store sink queuing DATA stores in a FIFO and latching DONE stores
module mmio_store_mailbox #(
  parameter int unsigned DEPTH = 8,
  parameter logic [31:0] BASE_ADDR = 32'd80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic        host_valid,
  output logic [31:0] host_data,
  input  logic        host_ready,
  output logic        done,
  output logic [31:0] done_value,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] DATA_A = BASE_ADDR;
  localparam logic [31:0] DONE_A = BASE_ADDR + 32'd4;
  localparam logic [31:0] STAT_A = BASE_ADDR + 32'd8;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic is_data, is_done, is_stat, push, pop, full, empty, acc;
  assign is_data = dataadr == DATA_A;
  assign is_done = dataadr == DONE_A;
  assign is_stat = dataadr == STAT_A;
  assign hit = is_data | is_done | is_stat;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign host_valid = ~empty;
  assign host_data = mem[rd_ptr];
  assign push = memwrite & is_data;
  assign pop = host_valid & host_ready;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign acc = push & (~full | pop);
  assign readdata = is_stat ? {16'h0, 8'(count), 4'h0, done, overflow, full, empty} : 32'h0;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      done <= 1'b0;
      done_value <= '0;
      overflow <= 1'b0;
    end else begin
      if (acc) begin
        mem[wr_ptr] <= writedata;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(acc) - (AW+1)'(pop);
      overflow <= overflow | (push & ~acc);
      if (memwrite & is_done) begin
        done <= 1'b1;
        done_value <= writedata;
      end
    end
  end
endmodule

// File: doc/mmio_store_mailbox.md
Name: mmio_store_mailbox

Overview:
- Memory-mapped store sink on the TopMIPS data bus. It sits at the consuming end of the memwrite/dataadr/writedata store interface.
- CPU stores to a small address window are captured into a FIFO. A host or test harness drains the FIFO over a valid/ready port.
- A store to the DONE address latches a completion flag and value. This is the hardware counterpart of the bench-side store checker.
- The top level uses `hit` to keep window accesses away from the data memory and to select `readdata`.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- BASE_ADDR, 32'd80, byte address of the DATA register; DONE = BASE_ADDR+4, STATUS = BASE_ADDR+8.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- memwrite  input  1  CPU store strobe, same cycle as dataadr/writedata.
- dataadr  input  32  CPU data byte address.
- writedata  input  32  CPU store data.
- readdata  output  32  combinational load data for window addresses; 0 otherwise.
- hit  output  1  combinational; 1 when dataadr equals DATA, DONE or STATUS.
- host_valid  output  1  FIFO head valid (~empty).
- host_data  output  32  FIFO head word, registered storage.
- host_ready  input  1  host accepts head word this cycle.
- done  output  1  sticky; set by a store to DONE.
- done_value  output  32  writedata captured with done.
- overflow  output  1  sticky; a DATA store was dropped because the FIFO was full.

Behaviour:
- Reset values on the first posedge with reset=1:
  - FIFO empty, count=0, read/write pointers=0.
  - host_valid=0, host_data=0 (storage cleared).
  - done=0, done_value=0, overflow=0.
- Reset mid-operation discards all queued words, with no pop handshake.
- Address decode:
  - Full 32-bit equality compare, so misaligned or partial matches are not a hit.
  - Stores to STATUS are ignored.
  - Loads from DATA or DONE return 0 on readdata.
- push = memwrite & (dataadr==DATA). pop = host_valid & host_ready.
- Push accepted when count<DEPTH, or when count==DEPTH and pop is in the same cycle.
- A rejected push sets overflow; the word is dropped and FIFO state is otherwise unchanged.
- Count update: push only → +1; pop only → −1; both accepted → unchanged (head advances, tail writes).
- Latency: a word pushed at edge N is visible on host_valid/host_data after edge N.
  - Push into an empty FIFO: host_valid=1 in the following cycle.
  - No same-cycle bypass.
- host_data is stable while host_valid=1 and host_ready=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Store to DONE:
  - done←1 and done_value←writedata.
  - A later DONE store overwrites done_value; done stays 1.
  - Only reset clears done.
- STATUS readdata layout:
  - [31:16] = 0
  - [15:8] = count, zero-extended
  - [7:4] = 0
  - [3] = done
  - [2] = overflow
  - [1] = full (count==DEPTH)
  - [0] = empty (count==0)
- STATUS reflects state before the current edge (pre-update values).
- memwrite=1 with a non-window address: no state change, hit=0.

Test Plan:
1. Reset held 2 cycles, then released → host_valid=0, done=0, overflow=0; STATUS read = 32'h00000001.
2. Store 7 to addr 80, host_ready=0 → next cycle host_valid=1, host_data=7; STATUS = 32'h00000100. Then host_ready=1 for one cycle → empty, host_valid=0.
3. Nine stores to 80 (values 1..9), host_ready=0:
   - STATUS = 32'h00000806; full=1, overflow=1.
   - Draining yields 1..8 in order.
   - Pointers wrap correctly on a second fill of 8 after the drain.
4. FIFO full, simultaneous store of 42 to 80 and host_ready=1 → head popped, 42 accepted, count stays 8, overflow unchanged.
5. Store 241 to addr 84 → done=1, done_value=241. Store 5 to 84 → done_value=5, done=1. Store to 88 and stores to 92/81 → no effect, hit=0 for 92/81.
6. Reset asserted with 3 words queued and done=1 → next cycle all outputs at reset values; a subsequent store to 80 works normally.
